// File: rtl/ccu_cmd_sched.sv
// rtl/ccu_cmd_sched.sv - two-requester command FIFO and issue sequencer in front of the CCU
//
// Purpose:
//   Accepts 8-bit commands from two requesters over valid/ready and buffers them
//   in a DEPTH-entry FIFO. Commands are issued one at a time on ccu_cmd and held
//   for cmd[7:6]+1 cycles. Consecutive commands are issued back-to-back with no
//   NOP gap.
//
// Configuration:
//   CCU_SCHED_FIXED_PRIO_EN - when defined, requester 0 always wins contention
//                             and no round-robin state exists. When undefined,
//                             contention is resolved round-robin.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0_valid/req0_cmd/req0_ready  requester 0 handshake
//   req1_valid/req1_cmd/req1_ready  requester 1 handshake
//   ccu_cmd                      registered command to the CCU (NOP_CMD when idle)
//   ccu_start                    one-cycle pulse on the first cycle of each command
//   busy                         a command occupies the CCU
//   fifo_level                   FIFO occupancy 0..DEPTH
//   issued_cnt                   wrapping count of issued commands

module ccu_cmd_sched #(
  parameter int          DEPTH   = 4,
  parameter int          AW      = 2,
  parameter logic [7:0]  NOP_CMD = 8'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [7:0]    req0_cmd,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_cmd,
  output logic          req1_ready,
  output logic [7:0]    ccu_cmd,
  output logic          ccu_start,
  output logic          busy,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   issued_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // FIFO storage and pointers
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full, empty;
  logic          push, pop;
  logic [7:0]    push_data;
  logic [7:0]    head;

  // Issue FSM state
  state_t        state_q, state_d;
  logic [1:0]    rem_q, rem_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic [15:0]   issued_cnt_q, issued_cnt_d;
  logic          can_load;

  logic          gnt0, gnt1;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // ------------------------------------------------------------------
  // Arbitration. Full blocks both requesters even if a pop happens in
  // the same cycle, so ready never depends on the issue FSM.
  // ------------------------------------------------------------------
`ifdef CCU_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt0 = req0_valid && !full;
    gnt1 = req1_valid && !req0_valid && !full;
  end
`else
  // prio_q names the requester favoured on contention. Each accepted push
  // hands the favour to the requester that was not granted, so reset value 0
  // lets requester 0 win the first contention.
  logic prio_q, prio_d;

  always_comb begin
    gnt0   = req0_valid && !full && (!req1_valid || (prio_q == 1'b0));
    gnt1   = req1_valid && !full && (!req0_valid || (prio_q == 1'b1));
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign push       = gnt0 || gnt1;
  assign push_data  = gnt0 ? req0_cmd : req1_cmd;

  // ------------------------------------------------------------------
  // Issue FSM. The last cycle of a command (rem==0) doubles as a load
  // slot, which is what makes back-to-back issue gapless.
  // ------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cmd_d        = cmd_q;
    start_d      = 1'b0;
    busy_d       = busy_q;
    issued_cnt_d = issued_cnt_q;
    pop          = 1'b0;
    can_load     = (state_q == IDLE) || (rem_q == 2'd0);

    if (can_load) begin
      if (!empty) begin
        pop          = 1'b1;
        cmd_d        = head;
        rem_d        = head[7:6];
        start_d      = 1'b1;
        busy_d       = 1'b1;
        issued_cnt_d = issued_cnt_q + 16'd1;
        state_d      = EXEC;
      end else begin
        cmd_d        = NOP_CMD;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    end else begin
      rem_d = rem_q - 2'd1;
    end
  end

  // ------------------------------------------------------------------
  // FIFO pointer / occupancy update
  // ------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= IDLE;
      rem_q        <= 2'd0;
      cmd_q        <= NOP_CMD;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      issued_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      rem_q        <= rem_d;
      cmd_q        <= cmd_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say
  // they were written after the last reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign ccu_cmd    = cmd_q;
  assign ccu_start  = start_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_ccu_cmd_sched.sv
// tb/tb_ccu_cmd_sched.sv - self-checking bench for ccu_cmd_sched with a queue-based reference model

module tb_ccu_cmd_sched;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_cmd, req1_cmd;
  logic        req0_ready, req1_ready;
  logic [7:0]  ccu_cmd;
  logic        ccu_start, busy;
  logic [AW:0] fifo_level;
  logic [15:0] issued_cnt;

  ccu_cmd_sched #(.DEPTH(DEPTH), .AW(AW), .NOP_CMD(8'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_cmd   (req0_cmd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_cmd   (req1_cmd),
    .req1_ready (req1_ready),
    .ccu_cmd    (ccu_cmd),
    .ccu_start  (ccu_start),
    .busy       (busy),
    .fifo_level (fifo_level),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain queue plus "cycles left" of the running command.
  logic [7:0]  mq[$];
  logic [7:0]  m_cmd;
  int          m_left;
  bit          m_start, m_busy;
  logic [15:0] m_cnt;
  int          m_last;     // requester granted most recently
  bit          g0, g1;     // grants seen on the last step
  int          glog[$];
  logic [7:0]  slog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cmd   = 8'd0;
    m_left  = 0;
    m_start = 0;
    m_busy  = 0;
    m_cnt   = 16'd0;
    m_last  = 1;
  endtask

  // Compare at negedge, advance the model across the next posedge,
  // return 1 ns after that posedge so the caller can drive new inputs.
  task automatic step();
    bit full, fav0, r0, r1;
    @(negedge clk);
    full = (mq.size() == DEPTH);
`ifdef CCU_SCHED_FIXED_PRIO_EN
    fav0 = 1;
`else
    fav0 = (m_last == 1);
`endif
    r0 = !full && req0_valid && (!req1_valid || fav0);
    r1 = !full && req1_valid && (!req0_valid || !fav0);
    chk("ccu_cmd",    ccu_cmd,    m_cmd);
    chk("ccu_start",  ccu_start,  m_start);
    chk("busy",       busy,       m_busy);
    chk("fifo_level", fifo_level, mq.size());
    chk("issued_cnt", issued_cnt, m_cnt);
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    if (ccu_start) slog.push_back(ccu_cmd);
    g0 = r0;
    g1 = r1;
    if (!rst_n) begin
      model_reset();
      g0 = 0;
      g1 = 0;
    end else begin
      if (m_left <= 1) begin
        if (mq.size() > 0) begin
          m_cmd   = mq.pop_front();
          m_left  = int'(m_cmd[7:6]) + 1;
          m_start = 1;
          m_busy  = 1;
          m_cnt   = m_cnt + 16'd1;
        end else begin
          m_cmd   = 8'd0;
          m_left  = 0;
          m_start = 0;
          m_busy  = 0;
        end
      end else begin
        m_left  = m_left - 1;
        m_start = 0;
      end
      if (r0) begin
        mq.push_back(req0_cmd);
        m_last = 0;
        glog.push_back(0);
      end else if (r1) begin
        mq.push_back(req1_cmd);
        m_last = 1;
        glog.push_back(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 0;
    req1_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0] exp_b2b_cmd [5];
  logic       exp_b2b_st  [5];
  int         exp_rr      [4];
  int         tmo;

  initial begin
    rst_n      = 0;
    req0_valid = 0;
    req1_valid = 0;
    req0_cmd   = 8'd0;
    req1_cmd   = 8'd0;
    model_reset();
    #1;
    step();
    step();
    chk("rst_ccu_cmd", ccu_cmd, 8'h00);
    chk("rst_level",   fifo_level, 0);
    rst_n = 1;
    idle(2);

    // Single long command: push at edge 1, issue at edge 2, held 4 cycles.
    req0_valid = 1;
    req0_cmd   = 8'hC4;
    step();
    req0_valid = 0;
    step();
    chk("single_start", ccu_start, 1'b1);
    chk("single_cmd0",  ccu_cmd, 8'hC4);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("single_hold", ccu_cmd, 8'hC4);
    end
    step();
    chk("single_end_cmd",  ccu_cmd, 8'h00);
    chk("single_end_busy", busy, 1'b0);
    chk("single_cnt",      issued_cnt, 16'd1);
    idle(2);

    // Back-to-back 02, 44, 06.
    exp_b2b_cmd = '{8'h02, 8'h44, 8'h44, 8'h06, 8'h00};
    exp_b2b_st  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    req0_valid = 1;
    req0_cmd   = 8'h02;
    step();
    req0_cmd = 8'h44;
    step();
    chk("b2b_cmd", ccu_cmd, exp_b2b_cmd[0]);
    chk("b2b_st",  ccu_start, exp_b2b_st[0]);
    req0_cmd = 8'h06;
    step();
    req0_valid = 0;
    chk("b2b_cmd", ccu_cmd, exp_b2b_cmd[1]);
    chk("b2b_st",  ccu_start, exp_b2b_st[1]);
    for (int i = 2; i < 5; i++) begin
      step();
      chk("b2b_cmd", ccu_cmd, exp_b2b_cmd[i]);
      chk("b2b_st",  ccu_start, exp_b2b_st[i]);
    end

    // Reset mid-execution with a queued command behind it.
    req0_valid = 1;
    req0_cmd   = 8'hC4;
    step();
    req0_cmd = 8'hC8;
    step();
    req0_valid = 0;
    step();
    rst_n = 0;
    #1;
    chk("arst_cmd",   ccu_cmd,    8'h00);
    chk("arst_busy",  busy,       1'b0);
    chk("arst_start", ccu_start,  1'b0);
    chk("arst_level", fifo_level, 0);
    chk("arst_cnt",   issued_cnt, 16'd0);
    model_reset();
    step();
    step();
    rst_n = 1;
    idle(3);
    chk("post_rst_cmd", ccu_cmd, 8'h00);

    // Contention: both hold valid continuously.
`ifdef CCU_SCHED_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif
    glog.delete();
    req0_valid = 1;
    req0_cmd   = 8'h10;
    req1_valid = 1;
    req1_cmd   = 8'h20;
    for (int i = 0; i < 4; i++) step();
    chk("rr_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_grant", glog[i], exp_rr[i]);
    idle(10);

    // Full backpressure: six long commands from requester 0.
    slog.delete();
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1;
      req0_cmd   = 8'hC0 + 8'(k);
      tmo = 0;
      do begin
        step();
        tmo++;
      end while (!g0 && tmo < 40);
      if (!g0) begin
        failures++;
        $display("FAIL bp_push_timeout actual=%0d required=accept", k);
      end
      if (k == 4) begin
        req0_cmd = 8'hC5;
        chk("bp_full_level", fifo_level, 3'd4);
        chk("bp_full_ready", req0_ready, 1'b0);
      end
    end
    idle(30);
    chk("bp_count", slog.size(), 6);
    for (int k = 0; k < 6 && k < slog.size(); k++) chk("bp_order", slog[k], 8'hC0 + 8'(k));

    // Counter wrap.
    force dut.issued_cnt_q = 16'hFFFF;
    #1;
    release dut.issued_cnt_q;
    m_cnt = 16'hFFFF;
    req0_valid = 1;
    req0_cmd   = 8'h01;
    step();
    req0_valid = 0;
    chk("wrap_pre", issued_cnt, 16'hFFFF);
    step();
    chk("wrap_post", issued_cnt, 16'h0000);
    idle(2);

    // Randomized traffic; requesters hold valid/cmd until accepted.
    for (int c = 0; c < 3000; c++) begin
      if (g0) req0_valid = 0;
      if (g1) req1_valid = 0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1;
        req0_cmd   = 8'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1;
        req1_cmd   = 8'($urandom);
      end
      step();
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
